lsu_store_queue: RTL and testbench

//  Load/store front-end that sits directly upstream of data_memory in the 2-way superscalar MEM stage.
//  - Buffers committed stores in an in-order FIFO and drains one per cycle into the memory write port.
//  - Arbitrates that single port between store drains and loads.
//  - Holds back any load whose byte range overlaps a pending store.
//  - Registers load data and sign-/zero-extends it.

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_load_extend.sv | 28 ++
 rtl/lsu_store_queue.sv | 173 +++++++++++++++++
 tb/tb_lsu_store_queue.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store front-end: access format codes,
// the store-queue entry layout and a byte-count helper.
package lsu_pkg;

  localparam int LSU_ADDR_W = 64;
  localparam int LSU_DATA_W = 64;

  // Store access sizes as driven on st_format / store_format
  localparam logic [1:0] ST_BYTE   = 2'b00;
  localparam logic [1:0] ST_HALF   = 2'b01;
  localparam logic [1:0] ST_WORD   = 2'b10;
  localparam logic [1:0] ST_DOUBLE = 2'b11;

  // Load access sizes as driven on ld_format / load_format
  localparam logic [2:0] LD_BYTE   = 3'b000;
  localparam logic [2:0] LD_HALF   = 3'b001;
  localparam logic [2:0] LD_WORD   = 3'b010;
  localparam logic [2:0] LD_DOUBLE = 3'b101;

  // One buffered store; sized by the package widths above
  typedef struct packed {
    logic [LSU_ADDR_W-1:0] addr;
    logic [LSU_DATA_W-1:0] data;
    logic [1:0]            fmt;
  } st_entry_t;

  // Byte count of an access. Store codes are passed zero-extended to three
  // bits, so 3'b011 is a store double and 3'b101 is a load double.
  function automatic logic [3:0] fmt_bytes(input logic [2:0] fmt);
    case (fmt)
      LD_BYTE:                  fmt_bytes = 4'd1;
      LD_HALF:                  fmt_bytes = 4'd2;
      LD_WORD:                  fmt_bytes = 4'd4;
      {1'b0, ST_DOUBLE}, LD_DOUBLE: fmt_bytes = 4'd8;
      default:                  fmt_bytes = 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Size-dependent sign/zero extension of raw load data returned by
// data_memory. Doubles and unknown codes pass the data through untouched.
module lsu_load_extend
  import lsu_pkg::*;
#(
  parameter int DATA_W = LSU_DATA_W
) (
  input  logic [2:0]        fmt,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] raw,
  output logic [DATA_W-1:0] ext
);

  // Pick the sign bit from the top of the accessed bytes and fill upward
  always_comb begin
    ext = raw;
    case (fmt)
      LD_BYTE: ext = is_unsigned ? {{(DATA_W-8){1'b0}}, raw[7:0]}
                                 : {{(DATA_W-8){raw[7]}}, raw[7:0]};
      LD_HALF: ext = is_unsigned ? {{(DATA_W-16){1'b0}}, raw[15:0]}
                                 : {{(DATA_W-16){raw[15]}}, raw[15:0]};
      LD_WORD: ext = is_unsigned ? {{(DATA_W-32){1'b0}}, raw[31:0]}
                                 : {{(DATA_W-32){raw[31]}}, raw[31:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/lsu_store_queue.sv
// Load/store front-end in front of data_memory. Committed stores sit in an
// in-order FIFO and drain one per cycle; loads share the single memory port
// and are held off while their bytes overlap any older pending store, which
// keeps read-after-write order without store-to-load forwarding.
module lsu_store_queue
  import lsu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = LSU_ADDR_W,
  parameter int DATA_W = LSU_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic [1:0]        st_format,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [2:0]        ld_format,
  input  logic              ld_unsigned,
  output logic              ld_resp_valid,
  output logic [DATA_W-1:0] ld_resp_data,
  output logic              mem_write_en,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_input,
  output logic [1:0]        store_format,
  output logic [2:0]        load_format,
  input  logic [DATA_W-1:0] mem_data_output
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  st_entry_t         queue [DEPTH];
  st_entry_t         head_entry;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  entry_off [DEPTH];
  logic [DEPTH-1:0]  entry_live;
  logic              full;
  logic              enq;
  logic              conflict;
  logic              do_drain;
  logic              do_load;
  logic [DATA_W-1:0] ext_data;

  // Half-open byte ranges [addr, addr+bytes) compared one bit wider than the
  // address so a range ending at the top of the address space cannot wrap to 0
  function automatic logic ranges_overlap(input logic [ADDR_W-1:0] a_addr,
                                          input logic [3:0]        a_bytes,
                                          input logic [ADDR_W-1:0] b_addr,
                                          input logic [3:0]        b_bytes);
    logic [ADDR_W:0] a_lo, a_hi, b_lo, b_hi;
    a_lo = {1'b0, a_addr};
    a_hi = a_lo + {{(ADDR_W-3){1'b0}}, a_bytes};
    b_lo = {1'b0, b_addr};
    b_hi = b_lo + {{(ADDR_W-3){1'b0}}, b_bytes};
    ranges_overlap = (a_lo < b_hi) && (b_lo < a_hi);
  endfunction

  assign full       = (count == CNT_W'(DEPTH));
  assign st_ready   = !full;
  assign enq        = st_valid && st_ready;
  assign head_entry = queue[head];
  assign ld_ready   = do_load;

  // A slot holds a pending store when its distance from head is below count
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_off[i]  = PTR_W'(i) - head;
      entry_live[i] = ({1'b0, entry_off[i]} < count);
    end
  end

  // The load conflicts with any pending store or with a store being
  // enqueued this same cycle, which is treated as older than the load
  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_live[i] &&
          ranges_overlap(queue[i].addr, fmt_bytes({1'b0, queue[i].fmt}),
                         ld_addr, fmt_bytes(ld_format)))
        conflict = 1'b1;
    end
    if (enq && ranges_overlap(st_addr, fmt_bytes({1'b0, st_format}),
                              ld_addr, fmt_bytes(ld_format)))
      conflict = 1'b1;
  end

  // Port arbitration: a full queue must drain, otherwise a clean load wins,
  // otherwise drain whatever is pending. Nothing reaches memory during reset
  // so a store caught mid-drain is discarded rather than written.
  always_comb begin
    do_drain = 1'b0;
    do_load  = 1'b0;
    if (!rst) begin
      if (full)
        do_drain = 1'b1;
      else if (ld_valid && !conflict)
        do_load = 1'b1;
      else if (count != '0)
        do_drain = 1'b1;
    end
  end

  // Memory-side request; idle and drain cycles keep the load format at byte
  always_comb begin
    mem_write_en   = do_drain;
    mem_read_en    = do_load;
    mem_addr       = '0;
    mem_data_input = '0;
    store_format   = ST_BYTE;
    load_format    = LD_BYTE;
    if (do_drain) begin
      mem_addr       = head_entry.addr;
      mem_data_input = head_entry.data;
      store_format   = head_entry.fmt;
    end else if (do_load) begin
      mem_addr    = ld_addr;
      load_format = ld_format;
    end
  end

  // Pointer and occupancy bookkeeping; enqueue and drain together keep count
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq)
        tail <= tail + 1'b1;
      if (do_drain)
        head <= head + 1'b1;
      case ({enq, do_drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage needs no reset because liveness comes from count
  always_ff @(posedge clk) begin
    if (enq && !rst)
      queue[tail] <= '{addr: st_addr, data: st_data, fmt: st_format};
  end

  lsu_load_extend #(.DATA_W(DATA_W)) u_extend (
    .fmt         (ld_format),
    .is_unsigned (ld_unsigned),
    .raw         (mem_data_output),
    .ext         (ext_data)
  );

  // Load response is a one-cycle pulse carrying the extended read data
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_resp_valid <= 1'b0;
      ld_resp_data  <= '0;
    end else begin
      ld_resp_valid <= do_load;
      if (do_load)
        ld_resp_data <= ext_data;
    end
  end

endmodule

// File: tb/tb_lsu_store_queue.sv
// Directed testbench for lsu_store_queue with a small byte-array model of
// data_memory (combinational read zero-padded above the access size,
// write on the clock edge).
module tb_lsu_store_queue;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [63:0] st_addr;
  logic [63:0] st_data;
  logic [1:0]  st_format;
  logic        ld_valid;
  logic        ld_ready;
  logic [63:0] ld_addr;
  logic [2:0]  ld_format;
  logic        ld_unsigned;
  logic        ld_resp_valid;
  logic [63:0] ld_resp_data;
  logic        mem_write_en;
  logic        mem_read_en;
  logic [63:0] mem_addr;
  logic [63:0] mem_data_input;
  logic [1:0]  store_format;
  logic [2:0]  load_format;
  logic [63:0] mem_data_output;

  int total = 0;
  int passed = 0;

  logic [7:0] mem [4096] = '{default: 8'h00};

  always #5 clk = ~clk;

  lsu_store_queue #(.DEPTH(4), .ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_format(st_format),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_format(ld_format), .ld_unsigned(ld_unsigned),
    .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
    .mem_addr(mem_addr), .mem_data_input(mem_data_input),
    .store_format(store_format), .load_format(load_format),
    .mem_data_output(mem_data_output)
  );

  function automatic int ld_bytes(input logic [2:0] f);
    case (f)
      3'b000:  return 1;
      3'b001:  return 2;
      3'b010:  return 4;
      3'b101:  return 8;
      default: return 1;
    endcase
  endfunction

  // Memory read model: only the accessed bytes, zeros above
  always_comb begin
    mem_data_output = '0;
    for (int i = 0; i < 8; i++)
      if (i < ld_bytes(load_format))
        mem_data_output[8*i +: 8] = mem[mem_addr[11:0] + 12'(i)];
  end

  // Memory write model: little-endian, size from store_format
  always @(posedge clk) begin
    if (mem_write_en)
      for (int i = 0; i < 8; i++)
        if (i < (1 << store_format))
          mem[mem_addr[11:0] + 12'(i)] <= mem_data_input[8*i +: 8];
  end

  task automatic drive_idle();
    st_valid    = 1'b0;
    st_addr     = '0;
    st_data     = '0;
    st_format   = ST_BYTE;
    ld_valid    = 1'b0;
    ld_addr     = '0;
    ld_format   = LD_BYTE;
    ld_unsigned = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    total++; if (dut.count !== 3'd0) $display("[TB] FAIL reset_count: got %0d expected 0", dut.count); else passed++;
    total++; if (st_ready !== 1'b1) $display("[TB] FAIL reset_st_ready: got %b expected 1", st_ready); else passed++;
    total++; if (ld_resp_valid !== 1'b0) $display("[TB] FAIL reset_resp_valid: got %b expected 0", ld_resp_valid); else passed++;
    total++; if (ld_resp_data !== 64'h0) $display("[TB] FAIL reset_resp_data: got %h expected 0", ld_resp_data); else passed++;
    total++; if ({mem_write_en, mem_read_en} !== 2'b00) $display("[TB] FAIL reset_enables: got %b expected 00", {mem_write_en, mem_read_en}); else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_store();
    @(negedge clk);
    st_valid = 1'b1; st_addr = 64'h100; st_data = 64'hDEAD_BEEF; st_format = ST_WORD;
    #1;
    total++; if (mem_write_en !== 1'b0) $display("[TB] FAIL sw_empty_idle: got %b expected 0", mem_write_en); else passed++;
    @(negedge clk);
    st_valid = 1'b0;
    #1;
    total++; if (mem_write_en !== 1'b1) $display("[TB] FAIL sw_drain_we: got %b expected 1", mem_write_en); else passed++;
    total++; if (mem_read_en !== 1'b0) $display("[TB] FAIL sw_drain_re: got %b expected 0", mem_read_en); else passed++;
    total++; if (mem_addr !== 64'h100) $display("[TB] FAIL sw_drain_addr: got %h expected 100", mem_addr); else passed++;
    total++; if (store_format !== 2'b10) $display("[TB] FAIL sw_drain_fmt: got %b expected 10", store_format); else passed++;
    total++; if (mem_data_input !== 64'hDEAD_BEEF) $display("[TB] FAIL sw_drain_data: got %h expected deadbeef", mem_data_input); else passed++;
    total++; if (load_format !== 3'b000) $display("[TB] FAIL sw_drain_ldfmt: got %b expected 000", load_format); else passed++;
    @(posedge clk); #1;
    total++; if (dut.count !== 3'd0) $display("[TB] FAIL sw_count_after: got %0d expected 0", dut.count); else passed++;
    total++; if (mem[12'h100] !== 8'hEF || mem[12'h103] !== 8'hDE) $display("[TB] FAIL sw_mem_bytes: got %h_%h expected de_ef", mem[12'h103], mem[12'h100]); else passed++;
    total++; if (mem[12'h104] !== 8'h00) $display("[TB] FAIL sw_mem_size: got %h expected 00", mem[12'h104]); else passed++;
  endtask

  task automatic test_fill();
    int n;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      st_valid = 1'b1; st_addr = 64'h500 + 64'(8*k); st_data = 64'h1111 * 64'(k+1); st_format = ST_DOUBLE;
      ld_valid = 1'b1; ld_addr = 64'h600; ld_format = LD_WORD; ld_unsigned = 1'b0;
      #1;
      total++; if (ld_ready !== 1'b1 || mem_write_en !== 1'b0) $display("[TB] FAIL fill_load_wins_%0d: got ready=%b we=%b expected ready=1 we=0", k, ld_ready, mem_write_en); else passed++;
    end
    @(negedge clk);
    st_valid = 1'b0;
    #1;
    total++; if (st_ready !== 1'b0) $display("[TB] FAIL full_st_ready: got %b expected 0", st_ready); else passed++;
    total++; if (ld_ready !== 1'b0) $display("[TB] FAIL full_ld_ready: got %b expected 0", ld_ready); else passed++;
    total++; if (mem_write_en !== 1'b1 || mem_addr !== 64'h500) $display("[TB] FAIL full_drain: got we=%b addr=%h expected we=1 addr=500", mem_write_en, mem_addr); else passed++;
    @(posedge clk); #1;
    total++; if (ld_resp_valid !== 1'b0) $display("[TB] FAIL full_no_resp: got %b expected 0", ld_resp_valid); else passed++;
    total++; if (dut.count !== 3'd3) $display("[TB] FAIL full_count3: got %0d expected 3", dut.count); else passed++;
    @(negedge clk); #1;
    total++; if (ld_ready !== 1'b1 || st_ready !== 1'b1 || mem_write_en !== 1'b0) $display("[TB] FAIL count3_load_accept: got ld=%b st=%b we=%b expected 1 1 0", ld_ready, st_ready, mem_write_en); else passed++;
    @(posedge clk); #1;
    total++; if (ld_resp_valid !== 1'b1 || ld_resp_data !== 64'h0) $display("[TB] FAIL count3_resp: got v=%b d=%h expected v=1 d=0", ld_resp_valid, ld_resp_data); else passed++;
    @(negedge clk);
    ld_valid = 1'b0;
    n = 0;
    while (dut.count != 3'd0 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    total++; if (dut.count !== 3'd0) $display("[TB] FAIL fill_drain_done: got %0d expected 0", dut.count); else passed++;
    total++; if (mem[12'h518] !== 8'h44 || mem[12'h519] !== 8'h44 || mem[12'h508] !== 8'h22) $display("[TB] FAIL fill_mem: got %h %h %h expected 44 44 22", mem[12'h518], mem[12'h519], mem[12'h508]); else passed++;
  endtask

  task automatic test_raw_conflict();
    @(negedge clk);
    st_valid = 1'b1; st_addr = 64'h200; st_data = 64'h8000_0000_0000_00FF; st_format = ST_DOUBLE;
    ld_valid = 1'b1; ld_addr = 64'h200; ld_format = LD_BYTE; ld_unsigned = 1'b0;
    #1;
    total++; if (ld_ready !== 1'b0) $display("[TB] FAIL raw_same_cycle: got %b expected 0", ld_ready); else passed++;
    total++; if ({mem_write_en, mem_read_en} !== 2'b00) $display("[TB] FAIL raw_same_cycle_idle: got %b expected 00", {mem_write_en, mem_read_en}); else passed++;
    @(negedge clk);
    st_valid = 1'b0;
    #1;
    total++; if (ld_ready !== 1'b0 || mem_write_en !== 1'b1 || mem_addr !== 64'h200) $display("[TB] FAIL raw_stall_drain: got ld=%b we=%b addr=%h expected 0 1 200", ld_ready, mem_write_en, mem_addr); else passed++;
    @(negedge clk); #1;
    total++; if (ld_ready !== 1'b1 || mem_read_en !== 1'b1 || mem_write_en !== 1'b0) $display("[TB] FAIL raw_accept: got ld=%b re=%b we=%b expected 1 1 0", ld_ready, mem_read_en, mem_write_en); else passed++;
    @(posedge clk); #1;
    total++; if (ld_resp_valid !== 1'b1 || ld_resp_data !== 64'hFFFF_FFFF_FFFF_FFFF) $display("[TB] FAIL raw_lb_data: got v=%b d=%h expected v=1 d=ffffffffffffffff", ld_resp_valid, ld_resp_data); else passed++;
    @(negedge clk);
    ld_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (ld_resp_valid !== 1'b0) $display("[TB] FAIL resp_pulse: got %b expected 0", ld_resp_valid); else passed++;
  endtask

  task automatic test_partial_overlap();
    @(negedge clk);
    st_valid = 1'b1; st_addr = 64'h300; st_data = 64'h1234; st_format = ST_HALF;
    @(negedge clk);
    st_valid = 1'b0;
    ld_valid = 1'b1; ld_addr = 64'h302; ld_format = LD_WORD; ld_unsigned = 1'b0;
    #1;
    total++; if (ld_ready !== 1'b1 || mem_write_en !== 1'b0) $display("[TB] FAIL lw302_accept: got ld=%b we=%b expected 1 0", ld_ready, mem_write_en); else passed++;
    @(negedge clk);
    ld_addr = 64'h2FE;
    #1;
    total++; if (ld_resp_valid !== 1'b1 || ld_resp_data !== 64'h0) $display("[TB] FAIL lw302_resp: got v=%b d=%h expected v=1 d=0", ld_resp_valid, ld_resp_data); else passed++;
    total++; if (ld_ready !== 1'b0 || mem_write_en !== 1'b1 || store_format !== 2'b01) $display("[TB] FAIL lw2fe_stall: got ld=%b we=%b fmt=%b expected 0 1 01", ld_ready, mem_write_en, store_format); else passed++;
    @(negedge clk); #1;
    total++; if (ld_ready !== 1'b1 || mem_addr !== 64'h2FE || load_format !== 3'b010) $display("[TB] FAIL lw2fe_accept: got ld=%b addr=%h fmt=%b expected 1 2fe 010", ld_ready, mem_addr, load_format); else passed++;
    @(posedge clk); #1;
    total++; if (ld_resp_data !== 64'h0000_0000_1234_0000) $display("[TB] FAIL lw2fe_data: got %h expected 0000000012340000", ld_resp_data); else passed++;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic test_extend();
    logic [63:0] t_addr [6] = '{64'h400, 64'h400, 64'h401, 64'h401, 64'h400, 64'h400};
    logic [2:0]  t_fmt  [6] = '{LD_HALF, LD_HALF, LD_BYTE, LD_BYTE, LD_WORD, LD_DOUBLE};
    logic        t_uns  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [63:0] t_exp  [6] = '{64'h8534, 64'hFFFF_FFFF_FFFF_8534, 64'h85,
                                64'hFFFF_FFFF_FFFF_FF85, 64'h8534, 64'h8534};
    @(negedge clk);
    st_valid = 1'b1; st_addr = 64'h400; st_data = 64'h8534; st_format = ST_HALF;
    @(negedge clk);
    st_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      ld_valid = 1'b1; ld_addr = t_addr[k]; ld_format = t_fmt[k]; ld_unsigned = t_uns[k];
      #1;
      total++; if (ld_ready !== 1'b1) $display("[TB] FAIL ext_accept_%0d: got %b expected 1", k, ld_ready); else passed++;
      @(posedge clk); #1;
      total++; if (ld_resp_valid !== 1'b1 || ld_resp_data !== t_exp[k]) $display("[TB] FAIL ext_data_%0d: got v=%b d=%h expected v=1 d=%h", k, ld_resp_valid, ld_resp_data, t_exp[k]); else passed++;
    end
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic test_top_of_space();
    @(negedge clk);
    st_valid = 1'b1; st_addr = 64'hFFFF_FFFF_FFFF_FFFF; st_data = 64'hAB; st_format = ST_BYTE;
    ld_valid = 1'b1; ld_addr = 64'hFFFF_FFFF_FFFF_FFF8; ld_format = LD_DOUBLE; ld_unsigned = 1'b0;
    #1;
    total++; if (ld_ready !== 1'b0) $display("[TB] FAIL top_same_cycle: got %b expected 0", ld_ready); else passed++;
    @(negedge clk);
    st_valid = 1'b0;
    #1;
    total++; if (ld_ready !== 1'b0 || mem_write_en !== 1'b1) $display("[TB] FAIL top_pending: got ld=%b we=%b expected 0 1", ld_ready, mem_write_en); else passed++;
    @(negedge clk); #1;
    total++; if (ld_ready !== 1'b1) $display("[TB] FAIL top_accept: got %b expected 1", ld_ready); else passed++;
    @(posedge clk); #1;
    total++; if (ld_resp_data !== 64'hAB00_0000_0000_0000) $display("[TB] FAIL top_data: got %h expected ab00000000000000", ld_resp_data); else passed++;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic seen_we;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      st_valid = 1'b1; st_addr = 64'h800 + 64'(8*k); st_data = 64'hA5A5_0000 + 64'(k+1); st_format = ST_DOUBLE;
      ld_valid = 1'b1; ld_addr = 64'h400; ld_format = LD_HALF; ld_unsigned = 1'b1;
    end
    @(negedge clk);
    st_valid = 1'b0;
    rst = 1'b1;
    #1;
    total++; if (mem_write_en !== 1'b0 || ld_ready !== 1'b0) $display("[TB] FAIL rst_cycle_quiet: got we=%b ld=%b expected 0 0", mem_write_en, ld_ready); else passed++;
    @(posedge clk); #1;
    total++; if (dut.count !== 3'd0) $display("[TB] FAIL rst_mid_count: got %0d expected 0", dut.count); else passed++;
    total++; if (ld_resp_valid !== 1'b0 || ld_resp_data !== 64'h0) $display("[TB] FAIL rst_mid_resp: got v=%b d=%h expected v=0 d=0", ld_resp_valid, ld_resp_data); else passed++;
    @(negedge clk);
    rst = 1'b0;
    ld_valid = 1'b0;
    seen_we = 1'b0;
    for (int j = 0; j < 4; j++) begin
      #1;
      if (mem_write_en === 1'b1) seen_we = 1'b1;
      @(negedge clk);
    end
    total++; if (seen_we !== 1'b0) $display("[TB] FAIL rst_no_drain: got we seen=%b expected 0", seen_we); else passed++;
    total++; if (mem[12'h800] !== 8'h00 || mem[12'h808] !== 8'h00 || mem[12'h810] !== 8'h00) $display("[TB] FAIL rst_mem_untouched: got %h %h %h expected 00 00 00", mem[12'h800], mem[12'h808], mem[12'h810]); else passed++;
  endtask

  // Absolute time limit so a stuck run still reports
  initial begin
    #200000;
    total++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    test_reset();
    test_single_store();
    test_fill();
    test_raw_conflict();
    test_partial_overlap();
    test_extend();
    test_top_of_space();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
